mult_sequencer: RTL and testbench

MULT_SEQUENCER -- requirements
Module: mult_sequencer

---
 rtl/mult_sequencer_pkg.sv | 25 ++
 rtl/mult_sequencer_if.sv | 31 +++
 rtl/mult_sequencer_iter_counter.sv | 26 ++
 rtl/mult_sequencer.sv | 114 +++++++++++
 tb/tb_mult_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_sequencer_pkg.sv
// Shared state encoding, register-mode codes and sizing for the add/shift multiplier
// sequencer and the datapath it controls.
package mult_pkg;

    localparam int N_BITS_DEFAULT = 8;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHIFT = 2'b01;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOADB,
        CLRA,
        ADD,
        SHIFT,
        HALT
    } state_t;

    // Keeps the iteration index at least one bit wide for degenerate N_BITS = 1.
    function automatic int iter_width(input int n_bits);
        return (n_bits > 1) ? $clog2(n_bits) : 1;
    endfunction

endpackage

// File: rtl/mult_sequencer_if.sv
// Request/control bundle between the multiplier sequencer (slave) and whoever
// drives its requests and observes its register-mode controls (master).
interface mult_sequencer_if
    import mult_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEFAULT
);
    localparam int ITER_W = iter_width(N_BITS);

    logic              RUN;
    logic              CLEARA_LOADB;
    logic              B0;
    logic              SUB;
    logic              CLEAR;
    logic [1:0]        MODE_A;
    logic [1:0]        MODE_B;
    logic              BUSY;
    logic              DONE;
    logic [ITER_W-1:0] ITER;

    modport master (
        output RUN, CLEARA_LOADB, B0,
        input  SUB, CLEAR, MODE_A, MODE_B, BUSY, DONE, ITER
    );

    modport slave (
        input  RUN, CLEARA_LOADB, B0,
        output SUB, CLEAR, MODE_A, MODE_B, BUSY, DONE, ITER
    );

endinterface

// File: rtl/mult_sequencer_iter_counter.sv
// Iteration index for the add/shift loop; wraps to zero after the last iteration
// so the index stays in range for any N_BITS.
module iter_counter #(
    parameter int N_BITS = 8,
    parameter int ITER_W = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              clear,
    input  logic              enable,
    output logic [ITER_W-1:0] iter,
    output logic              terminal
);
    localparam logic [ITER_W-1:0] LAST = ITER_W'(N_BITS - 1);

    always_ff @(posedge CLK) begin
        if (RESET || clear) begin
            iter <= '0;
        end else if (enable) begin
            iter <= terminal ? '0 : iter + ITER_W'(1);
        end
    end

    assign terminal = (iter == LAST);

endmodule

// File: rtl/mult_sequencer.sv
// Control FSM for a signed add/shift multiplier: one ADD and one SHIFT cycle per
// multiplier bit, with the final ADD subtracting to correct for the sign bit.
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEFAULT
) (
    input  logic          CLK,
    input  logic          RESET,
    mult_sequencer_if.slave bus
);
    localparam int ITER_W = iter_width(N_BITS);

    state_t            state;
    state_t            state_next;
    logic              cnt_clear;
    logic              cnt_enable;
    logic              cnt_terminal;
    logic [ITER_W-1:0] iter;

    logic              sub;
    logic              clear;
    logic [1:0]        mode_a;
    logic [1:0]        mode_b;
    logic              busy;
    logic              done;

    iter_counter #(
        .N_BITS (N_BITS),
        .ITER_W (ITER_W)
    ) u_iter (
        .CLK      (CLK),
        .RESET    (RESET),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .iter     (iter),
        .terminal (cnt_terminal)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        sub        = 1'b0;
        clear      = 1'b0;
        mode_a     = MODE_HOLD;
        mode_b     = MODE_HOLD;
        busy       = 1'b0;
        done       = 1'b0;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;

        case (state)
            IDLE: begin
                if (bus.RUN) begin
                    state_next = CLRA;
                end else if (bus.CLEARA_LOADB) begin
                    state_next = LOADB;
                end
            end
            LOADB: begin
                clear      = 1'b1;
                mode_a     = MODE_LOAD;
                mode_b     = MODE_LOAD;
                state_next = bus.RUN ? CLRA : IDLE;
            end
            CLRA: begin
                clear      = 1'b1;
                mode_a     = MODE_LOAD;
                busy       = 1'b1;
                cnt_clear  = 1'b1;
                state_next = ADD;
            end
            // The ADD cycle is spent even when B0 is 0 so the latency never depends on data.
            ADD: begin
                mode_a     = bus.B0 ? MODE_LOAD : MODE_HOLD;
                sub        = cnt_terminal;
                busy       = 1'b1;
                state_next = SHIFT;
            end
            SHIFT: begin
                mode_a     = MODE_SHIFT;
                mode_b     = MODE_SHIFT;
                busy       = 1'b1;
                cnt_enable = 1'b1;
                state_next = cnt_terminal ? HALT : ADD;
            end
            HALT: begin
                done = 1'b1;
                if (!bus.RUN) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.SUB    = sub;
    assign bus.CLEAR  = clear;
    assign bus.MODE_A = mode_a;
    assign bus.MODE_B = mode_b;
    assign bus.BUSY   = busy;
    assign bus.DONE   = done;
    assign bus.ITER   = iter;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer; includes a behavioural A/X/B datapath so whole
// multiplies can be checked against hand-computed products.
module tb_mult_sequencer;
    import mult_pkg::*;

    localparam int N = 8;

    // Packed observation: {SUB, CLEAR, MODE_A, MODE_B, BUSY, DONE}
    localparam logic [7:0] O_IDLE       = 8'b0_0_00_00_0_0;
    localparam logic [7:0] O_LOADB      = 8'b0_1_11_11_0_0;
    localparam logic [7:0] O_CLRA       = 8'b0_1_11_00_1_0;
    localparam logic [7:0] O_ADD1       = 8'b0_0_11_00_1_0;
    localparam logic [7:0] O_ADD1_LAST  = 8'b1_0_11_00_1_0;
    localparam logic [7:0] O_ADD0       = 8'b0_0_00_00_1_0;
    localparam logic [7:0] O_ADD0_LAST  = 8'b1_0_00_00_1_0;
    localparam logic [7:0] O_SHIFT      = 8'b0_0_01_01_1_0;
    localparam logic [7:0] O_HALT       = 8'b0_0_00_00_0_1;

    logic       CLK = 1'b0;
    logic       RESET;
    int         errors = 0;
    int         checks = 0;

    logic       use_model = 1'b0;
    logic       b0_manual = 1'b0;
    logic [7:0] s_in = 8'h00;
    logic [7:0] dp_a = 8'h00;
    logic [7:0] dp_b = 8'h00;
    logic       dp_x = 1'b0;
    logic [8:0] dp_sum;
    logic [7:0] outs;

    mult_sequencer_if #(.N_BITS(N)) bus ();

    mult_sequencer #(.N_BITS(N)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    assign bus.B0 = use_model ? dp_b[0] : b0_manual;
    assign outs   = {bus.SUB, bus.CLEAR, bus.MODE_A, bus.MODE_B, bus.BUSY, bus.DONE};
    assign dp_sum = bus.SUB ? ({dp_a[7], dp_a} - {s_in[7], s_in})
                            : ({dp_a[7], dp_a} + {s_in[7], s_in});

    // Datapath model: X:A loads the sign-extended sum (or zero under CLEAR), A shifts
    // right with X entering, B loads S or shifts right with A[0] entering.
    always @(posedge CLK) begin
        if (bus.MODE_A == MODE_LOAD) begin
            if (bus.CLEAR) begin
                dp_a <= 8'h00;
                dp_x <= 1'b0;
            end else begin
                dp_a <= dp_sum[7:0];
                dp_x <= dp_sum[8];
            end
        end else if (bus.MODE_A == MODE_SHIFT) begin
            dp_a <= {dp_x, dp_a[7:1]};
        end
        if (bus.MODE_B == MODE_LOAD) begin
            dp_b <= s_in;
        end else if (bus.MODE_B == MODE_SHIFT) begin
            dp_b <= {dp_a[0], dp_b[7:1]};
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        bus.RUN = 1'b1;
        bus.CLEARA_LOADB = 1'b1;
        tick();
        tick();
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", outs, O_IDLE);
        end
        checks++;
        if (bus.ITER !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_iter: got %0d expected 0", bus.ITER);
        end
        RESET = 1'b0;
        bus.RUN = 1'b0;
        bus.CLEARA_LOADB = 1'b0;
        tick();
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got %b expected %b", outs, O_IDLE);
        end
    endtask

    task automatic test_timing_b0_one;
        b0_manual = 1'b1;
        bus.RUN = 1'b1;
        tick();
        checks++;
        if (outs !== O_CLRA) begin
            errors++;
            $display("[TB] FAIL b1_clra: got %b expected %b", outs, O_CLRA);
        end
        for (int k = 0; k < N; k++) begin
            tick();
            checks++;
            if (outs !== ((k == N - 1) ? O_ADD1_LAST : O_ADD1) || bus.ITER !== 3'(k)) begin
                errors++;
                $display("[TB] FAIL b1_add%0d: got %b iter %0d expected %b iter %0d", k, outs,
                         bus.ITER, (k == N - 1) ? O_ADD1_LAST : O_ADD1, k);
            end
            tick();
            checks++;
            if (outs !== O_SHIFT || bus.ITER !== 3'(k)) begin
                errors++;
                $display("[TB] FAIL b1_shift%0d: got %b iter %0d expected %b iter %0d", k, outs,
                         bus.ITER, O_SHIFT, k);
            end
        end
        tick();
        checks++;
        if (outs !== O_HALT) begin
            errors++;
            $display("[TB] FAIL b1_done_at_17: got %b expected %b", outs, O_HALT);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (outs !== O_HALT) begin
                errors++;
                $display("[TB] FAIL halt_hold%0d: got %b expected %b", c, outs, O_HALT);
            end
        end
        bus.RUN = 1'b0;
        tick();
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("[TB] FAIL halt_release: got %b expected %b", outs, O_IDLE);
        end
    endtask

    task automatic test_timing_b0_zero;
        b0_manual = 1'b0;
        bus.RUN = 1'b1;
        tick();
        checks++;
        if (outs !== O_CLRA) begin
            errors++;
            $display("[TB] FAIL b0_clra: got %b expected %b", outs, O_CLRA);
        end
        bus.RUN = 1'b0;
        for (int k = 0; k < N; k++) begin
            tick();
            checks++;
            if (outs !== ((k == N - 1) ? O_ADD0_LAST : O_ADD0) || bus.ITER !== 3'(k)) begin
                errors++;
                $display("[TB] FAIL b0_add%0d: got %b iter %0d expected %b iter %0d", k, outs,
                         bus.ITER, (k == N - 1) ? O_ADD0_LAST : O_ADD0, k);
            end
            tick();
            checks++;
            if (outs !== O_SHIFT) begin
                errors++;
                $display("[TB] FAIL b0_shift%0d: got %b expected %b", k, outs, O_SHIFT);
            end
        end
        tick();
        checks++;
        if (outs !== O_HALT) begin
            errors++;
            $display("[TB] FAIL b0_done_at_17: got %b expected %b", outs, O_HALT);
        end
        tick();
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("[TB] FAIL b0_back_to_idle: got %b expected %b", outs, O_IDLE);
        end
    endtask

    task automatic test_reset_mid_op;
        b0_manual = 1'b1;
        bus.RUN = 1'b1;
        tick();
        bus.RUN = 1'b0;
        repeat (8) tick();
        checks++;
        if (outs !== O_SHIFT || bus.ITER !== 3'd3) begin
            errors++;
            $display("[TB] FAIL midop_setup: got %b iter %0d expected %b iter 3", outs, bus.ITER,
                     O_SHIFT);
        end
        RESET = 1'b1;
        tick();
        checks++;
        if (outs !== O_IDLE || bus.ITER !== 3'd0) begin
            errors++;
            $display("[TB] FAIL midop_reset: got %b iter %0d expected %b iter 0", outs, bus.ITER,
                     O_IDLE);
        end
        RESET = 1'b0;
        tick();
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("[TB] FAIL midop_stay_idle: got %b expected %b", outs, O_IDLE);
        end
    endtask

    task automatic test_loadb;
        bus.CLEARA_LOADB = 1'b1;
        tick();
        checks++;
        if (outs !== O_LOADB) begin
            errors++;
            $display("[TB] FAIL loadb_enter: got %b expected %b", outs, O_LOADB);
        end
        bus.CLEARA_LOADB = 1'b0;
        tick();
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("[TB] FAIL loadb_to_idle: got %b expected %b", outs, O_IDLE);
        end
        bus.CLEARA_LOADB = 1'b1;
        tick();
        bus.CLEARA_LOADB = 1'b0;
        bus.RUN = 1'b1;
        tick();
        checks++;
        if (outs !== O_CLRA) begin
            errors++;
            $display("[TB] FAIL loadb_to_clra: got %b expected %b", outs, O_CLRA);
        end
        bus.RUN = 1'b0;
        for (int c = 0; c < 40 && bus.DONE !== 1'b1; c++) tick();
        checks++;
        if (bus.DONE !== 1'b1) begin
            errors++;
            $display("[TB] FAIL loadb_run_timeout: got DONE=%b expected 1", bus.DONE);
        end
        tick();
    endtask

    task automatic test_busy_ignores_load;
        logic loadb_seen;
        loadb_seen = 1'b0;
        bus.RUN = 1'b1;
        bus.CLEARA_LOADB = 1'b1;
        tick();
        checks++;
        if (outs !== O_CLRA) begin
            errors++;
            $display("[TB] FAIL both_high_clra: got %b expected %b", outs, O_CLRA);
        end
        for (int c = 0; c < 16; c++) begin
            bus.CLEARA_LOADB = c[0];
            tick();
            if (bus.MODE_B === MODE_LOAD) loadb_seen = 1'b1;
        end
        checks++;
        if (loadb_seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_mode_b_load: got %b expected 0", loadb_seen);
        end
        bus.CLEARA_LOADB = 1'b1;
        tick();
        checks++;
        if (outs !== O_HALT) begin
            errors++;
            $display("[TB] FAIL halt_ignores_load: got %b expected %b", outs, O_HALT);
        end
        bus.RUN = 1'b0;
        bus.CLEARA_LOADB = 1'b0;
        tick();
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("[TB] FAIL busy_release: got %b expected %b", outs, O_IDLE);
        end
    endtask

    task automatic test_datapath(input logic [7:0] b_val, input logic [7:0] s_val,
                                 input logic [15:0] product);
        use_model = 1'b1;
        s_in = b_val;
        bus.CLEARA_LOADB = 1'b1;
        tick();
        bus.CLEARA_LOADB = 1'b0;
        tick();
        s_in = s_val;
        bus.RUN = 1'b1;
        for (int c = 0; c < 40 && bus.DONE !== 1'b1; c++) tick();
        checks++;
        if (bus.DONE !== 1'b1) begin
            errors++;
            $display("[TB] FAIL dp_timeout_%h_%h: got DONE=%b expected 1", b_val, s_val, bus.DONE);
        end
        checks++;
        if ({dp_a, dp_b} !== product) begin
            errors++;
            $display("[TB] FAIL dp_product_%h_%h: got %h expected %h", b_val, s_val, {dp_a, dp_b},
                     product);
        end
        bus.RUN = 1'b0;
        tick();
        use_model = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        bus.RUN = 1'b0;
        bus.CLEARA_LOADB = 1'b0;
        test_reset();
        test_timing_b0_one();
        test_timing_b0_zero();
        test_reset_mid_op();
        test_loadb();
        test_busy_ignores_load();
        test_datapath(8'h07, 8'h03, 16'h0015);
        test_datapath(8'h02, 8'hFF, 16'hFFFE);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
